gray_ptr_fifo_ctrl: RTL and testbench
=====================================

Name: gray_ptr_fifo_ctrl

Overview:
- Synchronous FIFO controller with one writer and one reader sharing a DEPTH-entry storage array.
- Read and write pointers are kept in binary and also published in registered Gray code.
- Full and empty are derived by comparing the Gray pointers.
- This is the single-clock precursor of the team's CDC FIFO: the Gray pointer outputs are the signals a later dual-clock version will synchronise.

Parameters:
- DEPTH_LOG2, 4, log2 of entry count (DEPTH = 16); legal range 2..8.
- DATA_W, 8, width of each stored word.
- PTR_W, DEPTH_LOG2+1, pointer width including the wrap bit; derived, not overridable.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- push_i  in  1  write request.
- push_data_i  in  DATA_W  write data, captured when a push is accepted.
- pop_i  in  1  read request.
- pop_data_o  out  DATA_W  head-of-queue word (show-ahead); valid while empty_o=0.
- full_o  out  1  FIFO holds DEPTH entries.
- empty_o  out  1  FIFO holds 0 entries.
- count_o  out  PTR_W  occupancy, 0..DEPTH.
- wr_ptr_gray_o  out  PTR_W  registered Gray write pointer.
- rd_ptr_gray_o  out  PTR_W  registered Gray read pointer.
- overflow_o  out  1  sticky: a push was attempted while full.
- underflow_o  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (reset_n=0 at an edge):
  - Binary and Gray pointers are 0; count_o=0; empty_o=1; full_o=0; overflow_o=0; underflow_o=0.
  - Storage contents are not reset; pop_data_o is don't-care while empty.
  - Reset mid-operation discards all entries on that edge. Any push or pop in the same cycle is ignored.
- Acceptance is evaluated against registered state at the start of the cycle:
  - push_ok = push_i & ~full_o
  - pop_ok = pop_i & ~empty_o
- On push_ok: mem[wr_bin[DEPTH_LOG2-1:0]] <= push_data_i; wr_bin increments by 1 modulo 2^PTR_W.
- On pop_ok: rd_bin increments by 1 modulo 2^PTR_W. pop_data_o is combinational from mem[rd_bin[DEPTH_LOG2-1:0]].
- Simultaneous push and pop:
  - When neither full nor empty, both are accepted and count is unchanged.
  - When full, only the pop is accepted.
  - When empty, only the push is accepted; the pushed word appears on pop_data_o the next cycle.
- Gray pointers:
  - Each is registered as bin2gray of the next binary value: g = b ^ (b >> 1).
  - Each is updated on the same edge as its binary pointer.
  - Exactly one bit changes per increment, including wrap from 2^PTR_W-1 to 0.
- empty_o (registered) = (next wr_gray == next rd_gray).
- full_o (registered) = next wr_gray equals next rd_gray with its top two bits inverted and all lower bits equal.
- count_o (registered) = next wr_bin - next rd_bin, modulo 2^PTR_W.
- Latency: a push accepted at edge N makes empty_o=0 and data visible from edge N. A pop accepted at edge N frees space visible from edge N.
- overflow_o sets on push_i & full_o; underflow_o sets on pop_i & empty_o. Both clear only on reset.

Optional Feature:
- Macro: GRAY_FIFO_ALMOST_FLAGS_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 2).
  - Adds outputs almost_full_o = registered (next count >= AF_LEVEL) and almost_empty_o = registered (next count <= AE_LEVEL).
  - Reset values: almost_full_o=0, almost_empty_o=1.
- When undefined: these ports and parameters do not exist, and the remaining behaviour is identical.

Decomposition:
- Package gray_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - typedef for a PTR_W-wide pointer;
  - a localparam computing DEPTH from DEPTH_LOG2.
- Sub-module gray_ptr_cnt:
  - inputs clk, reset_n, inc_i; outputs bin_o, bin_next_o, gray_o (PTR_W wide);
  - instantiated twice, once for the write pointer and once for the read pointer.
- Flag, count and storage logic stays in the top module.

Test Plan:
- Reset with push_i=pop_i=1 asserted → after the edge: empty_o=1, full_o=0, count_o=0, both Gray pointers 5'b00000, sticky flags 0.
- 16 pushes of 0x10..0x1F with DEPTH_LOG2=4 → full_o=1 after the 16th edge, count_o=16, wr_ptr_gray_o=5'b11000, rd_ptr_gray_o=5'b00000.
- 17th push of 0xAA while full → write pointer unchanged and overflow_o=1. The following 16 pops return 0x10..0x1F in order, then empty_o=1 and rd_ptr_gray_o=5'b11000.
- Pop while empty → underflow_o=1 and rd_ptr_gray_o unchanged. Then push 0x55 with pop held high → 0x55 is on pop_data_o one cycle later and is popped on the following edge.
- Continuous push and pop for 40 cycles starting at count_o=3 → count_o stays 3. Each Gray pointer changes exactly one bit per cycle, including the 31→0 wrap. Data order is preserved.
- With GRAY_FIFO_ALMOST_FLAGS_EN defined: fill to 14 → almost_full_o=1 at count 14 and 0 at count 13; drain → almost_empty_o=1 at count 2.

Source files
------------

// File: rtl/gray_fifo_pkg.sv
// Shared types, sizing constants and Gray-code helpers for the Gray-pointer FIFO family.
package gray_fifo_pkg;

   localparam int DEF_DEPTH_LOG2 = 4;
   localparam int DEF_DEPTH      = 1 << DEF_DEPTH_LOG2;
   localparam int DEF_PTR_W      = DEF_DEPTH_LOG2 + 1;
   localparam int MAX_PTR_W      = 9;

   typedef logic [DEF_PTR_W-1:0] ptr_t;

   // Operands are zero-extended to MAX_PTR_W, which leaves every narrower code unchanged.
   function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
      logic [MAX_PTR_W-1:0] b;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// Binary pointer with a registered Gray-code copy that moves on the same edge.
module gray_ptr_cnt
   import gray_fifo_pkg::*;
#(
   parameter int PTR_W = DEF_PTR_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc_i,
   output logic [PTR_W-1:0] bin_o,
   output logic [PTR_W-1:0] bin_next_o,
   output logic [PTR_W-1:0] gray_o
);

   logic [PTR_W-1:0] bin_r;
   logic [PTR_W-1:0] gray_r;
   logic [PTR_W-1:0] gray_next_s;

   // Next binary value and its Gray encoding.
   always_comb begin
      bin_next_o  = bin_r + PTR_W'(inc_i);
      gray_next_s = PTR_W'(bin2gray(MAX_PTR_W'(bin_next_o)));
   end

   // Pointer state, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bin_r  <= '0;
         gray_r <= '0;
      end else begin
         bin_r  <= bin_next_o;
         gray_r <= gray_next_s;
      end
   end

   assign bin_o  = bin_r;
   assign gray_o = gray_r;

endmodule

// File: rtl/gray_ptr_fifo_ctrl.sv
// Single-clock FIFO controller whose full/empty come from Gray pointer compares.
// Optional almost-full/almost-empty flags are enabled by defining GRAY_FIFO_ALMOST_FLAGS_EN.
module gray_ptr_fifo_ctrl
   import gray_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int DATA_W     = 8
`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2,
   parameter int AE_LEVEL   = 2
`endif
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [DATA_W-1:0]     push_data_i,
   input  logic                  pop_i,
   output logic [DATA_W-1:0]     pop_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic [DEPTH_LOG2:0]   wr_ptr_gray_o,
   output logic [DEPTH_LOG2:0]   rd_ptr_gray_o,
   output logic                  overflow_o,
   output logic                  underflow_o
`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
   ,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
`endif
);

   localparam int PTR_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem_r [DEPTH];
   logic                  full_r;
   logic                  empty_r;
   logic [PTR_W-1:0]      count_r;
   logic                  overflow_r;
   logic                  underflow_r;

   logic                  push_ok_s;
   logic                  pop_ok_s;
   logic [PTR_W-1:0]      wr_bin_s;
   logic [PTR_W-1:0]      wr_bin_next_s;
   logic [PTR_W-1:0]      wr_gray_s;
   logic [PTR_W-1:0]      rd_bin_s;
   logic [PTR_W-1:0]      rd_bin_next_s;
   logic [PTR_W-1:0]      rd_gray_s;
   logic [PTR_W-1:0]      wr_gray_next_s;
   logic [PTR_W-1:0]      rd_gray_next_s;
   logic [PTR_W-1:0]      rd_gray_full_s;
   logic [PTR_W-1:0]      count_next_s;
   logic [DEPTH_LOG2-1:0] wr_addr_s;
   logic [DEPTH_LOG2-1:0] rd_addr_s;

   assign push_ok_s = push_i & ~full_r;
   assign pop_ok_s  = pop_i & ~empty_r;

   gray_ptr_cnt #(.PTR_W(PTR_W)) u_wr_ptr (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (push_ok_s),
      .bin_o      (wr_bin_s),
      .bin_next_o (wr_bin_next_s),
      .gray_o     (wr_gray_s)
   );

   gray_ptr_cnt #(.PTR_W(PTR_W)) u_rd_ptr (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (pop_ok_s),
      .bin_o      (rd_bin_s),
      .bin_next_o (rd_bin_next_s),
      .gray_o     (rd_gray_s)
   );

   // Next-state Gray pointers and occupancy feeding the registered flags.
   always_comb begin
      wr_gray_next_s = PTR_W'(bin2gray(MAX_PTR_W'(wr_bin_next_s)));
      rd_gray_next_s = PTR_W'(bin2gray(MAX_PTR_W'(rd_bin_next_s)));
      // In Gray code a one-lap lead flips the top two bits, not just the wrap bit.
      rd_gray_full_s = {~rd_gray_next_s[PTR_W-1:PTR_W-2], rd_gray_next_s[PTR_W-3:0]};
      count_next_s   = wr_bin_next_s - rd_bin_next_s;
      wr_addr_s      = DEPTH_LOG2'(wr_bin_s);
      rd_addr_s      = DEPTH_LOG2'(rd_bin_s);
   end

   // Status flags, occupancy and sticky error bits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full_r      <= 1'b0;
         empty_r     <= 1'b1;
         count_r     <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         full_r      <= (wr_gray_next_s == rd_gray_full_s);
         empty_r     <= (wr_gray_next_s == rd_gray_next_s);
         count_r     <= count_next_s;
         overflow_r  <= overflow_r | (push_i & full_r);
         underflow_r <= underflow_r | (pop_i & empty_r);
      end
   end

   // Storage array; contents survive reset but no write happens on a reset edge.
   always_ff @(posedge clk) begin
      if (reset_n && push_ok_s) begin
         mem_r[wr_addr_s] <= push_data_i;
      end
   end

`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
   logic almost_full_r;
   logic almost_empty_r;

   // Threshold flags tracking the next occupancy.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else begin
         almost_full_r  <= (int'(count_next_s) >= AF_LEVEL);
         almost_empty_r <= (int'(count_next_s) <= AE_LEVEL);
      end
   end

   assign almost_full_o  = almost_full_r;
   assign almost_empty_o = almost_empty_r;
`endif

   assign pop_data_o    = mem_r[rd_addr_s];
   assign full_o        = full_r;
   assign empty_o       = empty_r;
   assign count_o       = count_r;
   assign wr_ptr_gray_o = wr_gray_s;
   assign rd_ptr_gray_o = rd_gray_s;
   assign overflow_o    = overflow_r;
   assign underflow_o   = underflow_r;

endmodule

// File: tb/tb_gray_ptr_fifo_ctrl.sv
// Directed bench for gray_ptr_fifo_ctrl at DEPTH_LOG2=4, DATA_W=8.
// Almost-flag checks are compiled in when GRAY_FIFO_ALMOST_FLAGS_EN is defined.
module tb_gray_ptr_fifo_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       push_i = 1'b0;
   logic [7:0] push_data_i = 8'h00;
   logic       pop_i = 1'b0;
   logic [7:0] pop_data_o;
   logic       full_o;
   logic       empty_o;
   logic [4:0] count_o;
   logic [4:0] wr_ptr_gray_o;
   logic [4:0] rd_ptr_gray_o;
   logic       overflow_o;
   logic       underflow_o;
`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
   logic       almost_full_o;
   logic       almost_empty_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gray_ptr_fifo_ctrl #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .push_i        (push_i),
      .push_data_i   (push_data_i),
      .pop_i         (pop_i),
      .pop_data_o    (pop_data_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .count_o       (count_o),
      .wr_ptr_gray_o (wr_ptr_gray_o),
      .rd_ptr_gray_o (rd_ptr_gray_o),
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o)
`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full_o (almost_full_o),
      .almost_empty_o(almost_empty_o)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; push_i = 1'b1; pop_i = 1'b1; push_data_i = 8'h77;
      tick();
      checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty_o); end
      checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full_o); end
      checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
      checks++; if (wr_ptr_gray_o !== 5'b00000) begin errors++; $display("FAIL reset_wr_gray got %b exp 00000", wr_ptr_gray_o); end
      checks++; if (rd_ptr_gray_o !== 5'b00000) begin errors++; $display("FAIL reset_rd_gray got %b exp 00000", rd_ptr_gray_o); end
      checks++; if ({overflow_o, underflow_o} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {overflow_o, underflow_o}); end
      reset_n = 1'b1; push_i = 1'b0; pop_i = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         push_i = 1'b1; push_data_i = 8'(8'h10 + i);
         tick();
         if (i == 0) begin
            checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL fill_first_empty got %0b exp 0", empty_o); end
         end
      end
      push_i = 1'b0;
      checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", full_o); end
      checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count_o); end
      checks++; if (wr_ptr_gray_o !== 5'b11000) begin errors++; $display("FAIL fill_wr_gray got %b exp 11000", wr_ptr_gray_o); end
      checks++; if (rd_ptr_gray_o !== 5'b00000) begin errors++; $display("FAIL fill_rd_gray got %b exp 00000", rd_ptr_gray_o); end
      checks++; if (pop_data_o !== 8'h10) begin errors++; $display("FAIL fill_head got %h exp 10", pop_data_o); end
   endtask

   task automatic test_overflow_drain();
      push_i = 1'b1; push_data_i = 8'hAA;
      tick();
      push_i = 1'b0;
      checks++; if (wr_ptr_gray_o !== 5'b11000) begin errors++; $display("FAIL ovf_wr_gray got %b exp 11000", wr_ptr_gray_o); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow_o); end
      checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count_o); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (pop_data_o !== 8'(8'h10 + i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, pop_data_o, 8'(8'h10 + i)); end
         pop_i = 1'b1;
         tick();
      end
      pop_i = 1'b0;
      checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b exp 1", empty_o); end
      checks++; if (rd_ptr_gray_o !== 5'b11000) begin errors++; $display("FAIL drain_rd_gray got %b exp 11000", rd_ptr_gray_o); end
      checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count_o); end
      checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL drain_underflow got %0b exp 0", underflow_o); end
   endtask

   task automatic test_underflow_passthru();
      pop_i = 1'b1;
      tick();
      checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL unf_flag got %0b exp 1", underflow_o); end
      checks++; if (rd_ptr_gray_o !== 5'b11000) begin errors++; $display("FAIL unf_rd_gray got %b exp 11000", rd_ptr_gray_o); end
      push_i = 1'b1; push_data_i = 8'h55;
      tick();
      push_i = 1'b0;
      checks++; if (pop_data_o !== 8'h55) begin errors++; $display("FAIL pass_data got %h exp 55", pop_data_o); end
      checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL pass_empty got %0b exp 0", empty_o); end
      checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL pass_count got %0d exp 1", count_o); end
      checks++; if (rd_ptr_gray_o !== 5'b11000) begin errors++; $display("FAIL pass_rd_hold got %b exp 11000", rd_ptr_gray_o); end
      tick();
      pop_i = 1'b0;
      checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL pass_popped_empty got %0b exp 1", empty_o); end
      checks++; if (rd_ptr_gray_o !== 5'b11001) begin errors++; $display("FAIL pass_rd_gray got %b exp 11001", rd_ptr_gray_o); end
      checks++; if (wr_ptr_gray_o !== 5'b11001) begin errors++; $display("FAIL pass_wr_gray got %b exp 11001", wr_ptr_gray_o); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] wr_b;
      logic [4:0] rd_b;
      logic [4:0] prev_w;
      logic [4:0] prev_r;
      wr_b = 5'd17; rd_b = 5'd17;
      for (int i = 0; i < 3; i++) begin
         push_i = 1'b1; push_data_i = 8'(8'h60 + i);
         tick();
         wr_b = wr_b + 5'd1;
      end
      checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL b2b_start_count got %0d exp 3", count_o); end
      for (int i = 0; i < 40; i++) begin
         push_i = 1'b1; pop_i = 1'b1; push_data_i = 8'(8'h63 + i);
         checks++; if (pop_data_o !== 8'(8'h60 + i)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, pop_data_o, 8'(8'h60 + i)); end
         prev_w = wr_ptr_gray_o; prev_r = rd_ptr_gray_o;
         tick();
         wr_b = wr_b + 5'd1; rd_b = rd_b + 5'd1;
         checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 3", i, count_o); end
         checks++; if ($countones(wr_ptr_gray_o ^ prev_w) != 1) begin errors++; $display("FAIL b2b_wr_onebit[%0d] got %b exp one bit from %b", i, wr_ptr_gray_o, prev_w); end
         checks++; if ($countones(rd_ptr_gray_o ^ prev_r) != 1) begin errors++; $display("FAIL b2b_rd_onebit[%0d] got %b exp one bit from %b", i, rd_ptr_gray_o, prev_r); end
         checks++; if (wr_ptr_gray_o !== (wr_b ^ (wr_b >> 1))) begin errors++; $display("FAIL b2b_wr_gray[%0d] got %b exp %b", i, wr_ptr_gray_o, wr_b ^ (wr_b >> 1)); end
         checks++; if (rd_ptr_gray_o !== (rd_b ^ (rd_b >> 1))) begin errors++; $display("FAIL b2b_rd_gray[%0d] got %b exp %b", i, rd_ptr_gray_o, rd_b ^ (rd_b >> 1)); end
      end
      push_i = 1'b0; pop_i = 1'b0;
      checks++; if (pop_data_o !== 8'h88) begin errors++; $display("FAIL b2b_end_head got %h exp 88", pop_data_o); end
   endtask

`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
   task automatic test_almost_flags();
      // Occupancy is 3 on entry.
      for (int i = 0; i < 10; i++) begin
         push_i = 1'b1; push_data_i = 8'(i);
         tick();
      end
      push_i = 1'b0;
      checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL af_at13 got %0b exp 0", almost_full_o); end
      checks++; if (almost_empty_o !== 1'b0) begin errors++; $display("FAIL ae_at13 got %0b exp 0", almost_empty_o); end
      push_i = 1'b1;
      tick();
      push_i = 1'b0;
      checks++; if (almost_full_o !== 1'b1) begin errors++; $display("FAIL af_at14 got %0b exp 1", almost_full_o); end
      for (int i = 0; i < 11; i++) begin
         pop_i = 1'b1;
         tick();
      end
      pop_i = 1'b0;
      checks++; if (almost_empty_o !== 1'b0) begin errors++; $display("FAIL ae_at3 got %0b exp 0", almost_empty_o); end
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
      checks++; if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL ae_at2 got %0b exp 1", almost_empty_o); end
      checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL ae_count got %0d exp 2", count_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_overflow_drain();
      test_underflow_passthru();
      test_back_to_back();
`ifdef GRAY_FIFO_ALMOST_FLAGS_EN
      test_almost_flags();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
